sound_frame_packer: RTL and testbench
=====================================

Name: sound_frame_packer

Overview:
- Downstream stage of the sound UART receiver.
- Consumes the received byte stream (rx_done_tick / 8-bit data) and packs bytes little-endian into 32-bit words.
- Writes words into a two-page (ping-pong) buffer, and swaps pages on every msec tick while start is high.
- The host side reads the last completed frame through rdaddress/q, so reads never collide with the page being filled.

Parameters:
- PAGE_AW, 9: word address width of one page. Page depth is 2**PAGE_AW = 512 words.
- PAD_BYTE, 8'h00: value used to fill the unused lanes of a partial word flushed at a frame boundary.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low; all state cleared while low.
- rx_done_tick  in  1  one-cycle strobe; rx_data is valid on this cycle.
- rx_data  in  8  received byte.
- msec  in  1  one-cycle frame-boundary pulse.
- start  in  1  level capture enable; low = idle.
- rdaddress  in  PAGE_AW  word address into the completed page.
- q  out  32  read data, registered.
- frame_ready  out  1  one-cycle pulse: a new completed page is readable.
- word_count  out  PAGE_AW+1  number of words in the completed page (0..512).
- overrun  out  1  completed frame dropped at least one byte.

Behaviour:
- Reset (rst low, async): the following are cleared.
  - Outputs: q=0, frame_ready=0, word_count=0, overrun=0.
  - Internal state: write page=0, read page=1, wr_addr=0, byte lane=0, shift register=0, overrun_acc=0.
  - RAM contents are not cleared.
- States: IDLE (start=0) and CAPTURE (start=1). The transition occurs on the start level each cycle.
- IDLE:
  - rx_done_tick is ignored.
  - wr_addr, byte lane and overrun_acc are held at 0.
  - Page select, word_count and the read path are unchanged.
  - msec is ignored.
- CAPTURE, byte handling:
  - On rx_done_tick, rx_data goes into lane[1:0]; byte 0 occupies bits [7:0].
  - On lane 3 the full word is written to RAM at {write page, wr_addr} in the next cycle, wr_addr increments, and lane wraps to 0.
- Page full: wr_addr==512 with a word pending.
  - The word and all further bytes are dropped until the next msec.
  - overrun_acc is set (sticky).
  - wr_addr saturates at 512 and never wraps.
- msec in CAPTURE: all of the following happen in one cycle.
  - If lane!=0 and the page is not full, the partial word is written with the unused upper lanes set to PAD_BYTE, and it is counted.
  - word_count is loaded with the final wr_addr and overrun is loaded with overrun_acc.
  - The write and read pages swap.
  - wr_addr, lane and overrun_acc are cleared.
  - frame_ready pulses high in the following cycle.
- msec and rx_done_tick in the same cycle:
  - The flush/swap is applied first.
  - The byte becomes lane 0 of the new frame in the new write page.
- start deasserted mid-frame:
  - The partial frame is discarded: no swap, no frame_ready.
  - word_count, overrun and the readable page keep their previous frame.
- Read path:
  - q <= RAM[{read page, rdaddress}], latency 1 clock.
  - After a swap, the new page is visible to reads from the cycle frame_ready is high.
  - Addresses >= word_count return stale data; this is defined as don't-care.
- Write and read never address the same page, so there are no read-during-write hazards.
- A reset pulse mid-frame aborts capture. After release the block is in IDLE or CAPTURE per start, with an empty frame.

Decomposition:
- Shared package (sound_pkg) holds:
  - SND_PAGE_AW = 9 and SND_WORD_W = 32;
  - lane index type (2 bits);
  - PAD_BYTE constant.
- One sub-module, sound_page_ram: simple dual-port 2**(PAGE_AW+1) x 32 RAM with one write port and a registered read port, inferable as block RAM.
- Packing, page control and status live in the top module.

Test Plan:
- Basic packing: start=1, bytes 11,22,33,44,55,66,77,88, then msec -> frame_ready 1 cycle after msec, word_count=2, overrun=0. rdaddress=0 gives q=44332211 next cycle; rdaddress=1 gives q=88776655.
- Partial flush: start=1, bytes A1,B2,C3, then msec -> word_count=1, q@0=00C3B2A1. The next frame lands in the other page, and the previous page is read back unchanged.
- Overrun: 2052 bytes in one frame, then msec -> word_count=512, overrun=1, q@511 holds bytes 2044..2047. The next clean frame of 4 bytes gives overrun=0.
- Coincident events: byte 5A on the same cycle as msec, then bytes 6B,7C,8D, then msec -> second frame word_count=1, q@0=8D7C6B5A.
- start drop: capture 3 words, start=0, start=1, 1 word, then msec -> word_count=1. No frame_ready pulse occurs during the aborted frame.
- Async reset: assert rst low mid-frame (not clock-aligned) -> q, frame_ready, word_count and overrun are 0 immediately. A post-release frame of 4 bytes gives word_count=1.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types and constants for the sound capture path.
// Also holds the helper that pads a partially filled word at a frame boundary.
package sound_pkg;

    localparam int unsigned SND_PAGE_AW  = 9;
    localparam int unsigned SND_WORD_W   = 32;
    localparam logic [7:0]  SND_PAD_BYTE = 8'h00;

    typedef logic [1:0] lane_t;

    typedef enum logic {
        ModeIdle,
        ModeCapture
    } snd_mode_e;

    // Build a word from the bytes collected so far; lanes at and above 'lane' get 'pad'.
    function automatic logic [SND_WORD_W-1:0] pad_word(input logic [23:0] bytes,
                                                       input lane_t       lane,
                                                       input logic [7:0]  pad);
        logic [SND_WORD_W-1:0] w;
        case (lane)
            2'd1:    w = {pad, pad, pad, bytes[7:0]};
            2'd2:    w = {pad, pad, bytes[15:0]};
            2'd3:    w = {pad, bytes[23:0]};
            default: w = {pad, pad, pad, pad};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sound_page_ram.sv
// Simple dual-port RAM holding both frame pages: one write port, one registered read port.
// Contents are never reset; only the read register is.
module sound_page_ram #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sound_frame_packer.sv
// Packs received UART bytes little-endian into 32-bit words and stores them in a
// ping-pong page buffer that swaps on every msec tick while capturing.
module sound_frame_packer
    import sound_pkg::*;
#(
    parameter int unsigned PAGE_AW  = SND_PAGE_AW,
    parameter logic [7:0]  PAD_BYTE = SND_PAD_BYTE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_done_tick,
    input  logic [7:0]            rx_data,
    input  logic                  msec,
    input  logic                  start,
    input  logic [PAGE_AW-1:0]    rdaddress,
    output logic [SND_WORD_W-1:0] q,
    output logic                  frame_ready,
    output logic [PAGE_AW:0]      word_count,
    output logic                  overrun
);

    snd_mode_e             mode;
    logic                  wr_page_q, wr_page_d;
    logic [PAGE_AW:0]      wr_addr_q, wr_addr_d;
    lane_t                 lane_q, lane_d;
    logic [23:0]           shift_q, shift_d;
    logic                  ovr_acc_q, ovr_acc_d;
    logic                  frame_ready_q, frame_ready_d;
    logic [PAGE_AW:0]      word_count_q, word_count_d;
    logic                  overrun_q, overrun_d;

    logic                  ram_we;
    logic [PAGE_AW:0]      ram_waddr;
    logic [SND_WORD_W-1:0] ram_wdata;

    assign mode = start ? ModeCapture : ModeIdle;

    always_comb begin
        logic             flush;
        lane_t            lane_v;
        logic [23:0]      shift_v;
        logic [PAGE_AW:0] addr_v;
        logic             ovr_v;

        wr_page_d     = wr_page_q;
        wr_addr_d     = wr_addr_q;
        lane_d        = lane_q;
        shift_d       = shift_q;
        ovr_acc_d     = ovr_acc_q;
        frame_ready_d = 1'b0;
        word_count_d  = word_count_q;
        overrun_d     = overrun_q;
        ram_we        = 1'b0;
        ram_waddr     = {wr_page_q, wr_addr_q[PAGE_AW-1:0]};
        ram_wdata     = pad_word(shift_q, lane_q, PAD_BYTE);
        flush         = 1'b0;
        lane_v        = lane_q;
        shift_v       = shift_q;
        addr_v        = wr_addr_q;
        ovr_v         = ovr_acc_q;

        case (mode)
            ModeIdle: begin
                wr_addr_d = '0;
                lane_d    = '0;
                shift_d   = '0;
                ovr_acc_d = 1'b0;
            end
            default: begin
                // Frame boundary is resolved before any byte arriving on the same cycle.
                if (msec) begin
                    flush         = (lane_q != 2'd0) && !wr_addr_q[PAGE_AW];
                    ram_we        = flush;
                    word_count_d  = wr_addr_q + {{PAGE_AW{1'b0}}, flush};
                    overrun_d     = ovr_acc_q;
                    wr_page_d     = ~wr_page_q;
                    frame_ready_d = 1'b1;
                    lane_v        = '0;
                    shift_v       = '0;
                    addr_v        = '0;
                    ovr_v         = 1'b0;
                end
                if (rx_done_tick) begin
                    if (addr_v[PAGE_AW]) begin
                        ovr_v = 1'b1;
                    end else if (lane_v == 2'd3) begin
                        ram_we    = 1'b1;
                        ram_waddr = {wr_page_q, addr_v[PAGE_AW-1:0]};
                        ram_wdata = {rx_data, shift_v};
                        addr_v    = addr_v + 1'b1;
                        lane_v    = '0;
                    end else begin
                        case (lane_v)
                            2'd0:    shift_v[7:0]   = rx_data;
                            2'd1:    shift_v[15:8]  = rx_data;
                            default: shift_v[23:16] = rx_data;
                        endcase
                        lane_v = lane_v + 1'b1;
                    end
                end
                wr_addr_d = addr_v;
                lane_d    = lane_v;
                shift_d   = shift_v;
                ovr_acc_d = ovr_v;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_page_q     <= 1'b0;
            wr_addr_q     <= '0;
            lane_q        <= '0;
            shift_q       <= '0;
            ovr_acc_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            word_count_q  <= '0;
            overrun_q     <= 1'b0;
        end else begin
            wr_page_q     <= wr_page_d;
            wr_addr_q     <= wr_addr_d;
            lane_q        <= lane_d;
            shift_q       <= shift_d;
            ovr_acc_q     <= ovr_acc_d;
            frame_ready_q <= frame_ready_d;
            word_count_q  <= word_count_d;
            overrun_q     <= overrun_d;
        end
    end

    sound_page_ram #(
        .AW (PAGE_AW + 1),
        .DW (SND_WORD_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr ({~wr_page_q, rdaddress}),
        .rdata (q)
    );

    assign frame_ready = frame_ready_q;
    assign word_count  = word_count_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_sound_frame_packer.sv
// Scoreboard bench for sound_frame_packer: stimulus queues expected reads and frame
// status, a negedge monitor pops and compares whenever the DUT presents them.
module tb_sound_frame_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_done_tick = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        msec = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  rdaddress = 9'd0;
    logic [31:0] q;
    logic        frame_ready;
    logic [9:0]  word_count;
    logic        overrun;

    always #5 clk = ~clk;

    sound_frame_packer dut (
        .clk          (clk),
        .rst          (rst),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .msec         (msec),
        .start        (start),
        .rdaddress    (rdaddress),
        .q            (q),
        .frame_ready  (frame_ready),
        .word_count   (word_count),
        .overrun      (overrun)
    );

    typedef struct {
        logic [31:0] data;
        string       name;
    } rd_exp_t;

    typedef struct {
        logic [9:0] wc;
        logic       ov;
        string      name;
    } fr_exp_t;

    rd_exp_t rd_q[$];
    fr_exp_t fr_q[$];
    rd_exp_t re;
    fr_exp_t fe;
    int      n_cmp = 0;
    int      n_err = 0;
    logic    rd_req = 1'b0;
    logic    rd_req_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_req_d <= rd_req;

    // Monitor: read data is due the cycle after a request; frame status on each frame_ready.
    always @(negedge clk) begin
        if (rd_req_d) begin
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: read data with no expectation queued");
            end else begin
                re = rd_q.pop_front();
                check(re.name, q, re.data);
            end
        end
        if (frame_ready) begin
            if (fr_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL frame_ready_spurious: got pulse, expected none");
            end else begin
                fe = fr_q.pop_front();
                check({fe.name, "_word_count"}, 32'(word_count), 32'(fe.wc));
                check({fe.name, "_overrun"}, 32'(overrun), 32'(fe.ov));
            end
        end
    end

    task automatic slot(input logic tick, input logic [7:0] d, input logic ms);
        rx_done_tick = tick;
        rx_data      = d;
        msec         = ms;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        msec         = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        slot(1'b1, d, 1'b0);
    endtask

    task automatic frame_end(input logic [9:0] wc, input logic ov, input string name);
        fr_q.push_back('{wc: wc, ov: ov, name: name});
        slot(1'b0, 8'h00, 1'b1);
    endtask

    task automatic rd(input logic [8:0] a, input logic [31:0] exp, input string name);
        rdaddress = a;
        rd_req    = 1'b1;
        rd_q.push_back('{data: exp, name: name});
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_q", q, 32'h0);
        check("reset_frame_ready", 32'(frame_ready), 32'h0);
        check("reset_word_count", 32'(word_count), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b1;

        // Basic packing
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66); send(8'h77); send(8'h88);
        frame_end(10'd2, 1'b0, "basic");
        rd(9'd0, 32'h4433_2211, "basic_q0");
        rd(9'd1, 32'h8877_6655, "basic_q1");

        // Partial flush, then next frame lands in the other page
        send(8'hA1); send(8'hB2); send(8'hC3);
        frame_end(10'd1, 1'b0, "partial");
        rd(9'd0, 32'h00C3_B2A1, "partial_q0");
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        rd(9'd0, 32'h00C3_B2A1, "prev_page_unchanged");
        frame_end(10'd1, 1'b0, "after_partial");
        rd(9'd0, 32'hEFBE_ADDE, "after_partial_q0");

        // Two-byte partial
        send(8'h9A); send(8'hBC);
        frame_end(10'd1, 1'b0, "pad2");
        rd(9'd0, 32'h0000_BC9A, "pad2_q0");

        // Overrun: 2052 bytes into a 512-word page
        for (int i = 0; i < 2052; i++) send(8'(i));
        frame_end(10'd512, 1'b1, "overrun");
        rd(9'd511, 32'hFFFE_FDFC, "overrun_q511");
        rd(9'd0, 32'h0302_0100, "overrun_q0");
        send(8'h10); send(8'h20); send(8'h30); send(8'h40);
        frame_end(10'd1, 1'b0, "clean_after_overrun");
        rd(9'd0, 32'h4030_2010, "clean_q0");

        // Byte coincident with msec starts the new frame
        fr_q.push_back('{wc: 10'd0, ov: 1'b0, name: "coinc_empty"});
        slot(1'b1, 8'h5A, 1'b1);
        send(8'h6B); send(8'h7C); send(8'h8D);
        frame_end(10'd1, 1'b0, "coinc");
        rd(9'd0, 32'h8D7C_6B5A, "coinc_q0");

        // start dropped mid-frame; msec while idle must be ignored
        for (int i = 0; i < 12; i++) send(8'(i + 8'hE0));
        start = 1'b0;
        slot(1'b0, 8'h00, 1'b1);
        slot(1'b0, 8'h00, 1'b0);
        start = 1'b1;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        frame_end(10'd1, 1'b0, "start_drop");
        rd(9'd0, 32'h0403_0201, "start_drop_q0");

        // Async reset mid-frame, off the clock edge
        send(8'h55); send(8'h66);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_q", q, 32'h0);
        check("async_rst_frame_ready", 32'(frame_ready), 32'h0);
        check("async_rst_word_count", 32'(word_count), 32'h0);
        check("async_rst_overrun", 32'(overrun), 32'h0);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(8'hC0); send(8'hC1); send(8'hC2); send(8'hC3);
        frame_end(10'd1, 1'b0, "post_reset");
        rd(9'd0, 32'hC3C2_C1C0, "post_reset_q0");

        for (int i = 0; i < 20 && (rd_q.size() != 0 || fr_q.size() != 0); i++) begin
            @(posedge clk);
        end
        #1;
        if (rd_q.size() != 0 || fr_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d reads and %0d frames still expected, expected 0",
                     rd_q.size(), fr_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
